ram_sp_param: RTL and testbench

//  Parametrised single-port synchronous RAM, successor to the fixed 8x128 RAM.

---
 rtl/ram_sp_param.sv | 144 ++++++++++++++
 tb/tb_ram_sp_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_param.sv
// ram_sp_param: single-port synchronous RAM with byte enables, range check and clear sequencer.
// Define RAM_SP_OUTREG_EN to add a second output register stage (read/err latency 2).
module ram_sp_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [DATA_W-1:0]     din,
   output logic                  ready,
   output logic                  busy,
   output logic [DATA_W-1:0]     dout,
   output logic                  dout_valid,
   output logic                  err
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   clr_ptr_q;
   logic                busy_q;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                accept;
   logic                rd_acc;
   logic                in_range;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    clr_idx;
   logic [DATA_W-1:0]   rd_data_d;

   logic [DATA_W-1:0]   dout1_q;
   logic                valid1_q;
   logic                err1_q;

   assign ready    = (state_q == ST_IDLE) & ~clr;
   assign accept   = req & ready;
   assign rd_acc   = accept & ~we;
   assign in_range = 32'(addr) < 32'(DEPTH);
   // Narrowing is safe: idx is only used when in_range, clr_ptr never exceeds DEPTH-1.
   assign idx      = addr[IDX_W-1:0];
   assign clr_idx  = clr_ptr_q[IDX_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (32'(clr_ptr_q) == DEPTH - 1) begin
                  state_q   <= ST_IDLE;
                  busy_q    <= 1'b0;
                  clr_ptr_q <= '0;
               end else begin
                  clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
               end
            end
            ST_IDLE: begin
               if (clr) begin
                  state_q   <= ST_CLEAR;
                  busy_q    <= 1'b1;
                  clr_ptr_q <= '0;
               end
            end
            default: begin
               state_q   <= ST_CLEAR;
               busy_q    <= 1'b1;
               clr_ptr_q <= '0;
            end
         endcase
      end
   end

   // Clear writes and master accesses never coincide: ready is low throughout CLEAR.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem[clr_idx] <= '0;
      end else if (accept && we && in_range) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= din[8*b +: 8];
         end
      end
   end

   always_comb begin
      rd_data_d = '0;
      if (in_range) rd_data_d = mem[idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout1_q  <= '0;
         valid1_q <= 1'b0;
         err1_q   <= 1'b0;
      end else begin
         valid1_q <= rd_acc;
         err1_q   <= accept & ~in_range;
         if (rd_acc) dout1_q <= rd_data_d;
      end
   end

`ifdef RAM_SP_OUTREG_EN
   logic [DATA_W-1:0]   dout2_q;
   logic                valid2_q;
   logic                err2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout2_q  <= '0;
         valid2_q <= 1'b0;
         err2_q   <= 1'b0;
      end else begin
         dout2_q  <= dout1_q;
         valid2_q <= valid1_q;
         err2_q   <= err1_q;
      end
   end

   assign dout       = dout2_q;
   assign dout_valid = valid2_q;
   assign err        = err2_q;
`else
   assign dout       = dout1_q;
   assign dout_valid = valid1_q;
   assign err        = err1_q;
`endif

   assign busy = busy_q;

endmodule

// File: tb/tb_ram_sp_param.sv
// Bench for ram_sp_param (32-bit words, 100 of 128 addresses implemented) against an array/queue model.
module tb_ram_sp_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 100;
  localparam int BE_W   = DATA_W / 8;
`ifdef RAM_SP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // clock / reset / stimulus signals
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clr = 1'b0;
  logic              req = 1'b0;
  logic              we  = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [BE_W-1:0]   be   = '0;
  logic [DATA_W-1:0] din  = '0;
  logic              ready;
  logic              busy;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              err;

  ram_sp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .be         (be),
    .din        (din),
    .ready      (ready),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  // scoreboard: result due on a given cycle
  typedef struct {
    int                due;
    bit                valid;
    bit                err;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] model_mem [2**ADDR_W];
  logic [DATA_W-1:0] last_dout;
  int                clear_left;
  int                cyc;
  int                n_checks;
  int                n_fails;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_dout  = '0;
    clear_left = DEPTH;
    for (int i = 0; i < 2**ADDR_W; i++) model_mem[i] = '0;
  endtask

  // One clock cycle: check ready before the edge, advance the model, check outputs after.
  task automatic tick();
    bit   exp_rdy;
    bit   acc;
    bit   e_valid;
    bit   e_err;
    exp_t e;
    exp_rdy = !rst && clear_left == 0 && !clr;
    #1;
    chk("ready", DATA_W'(ready), DATA_W'(exp_rdy));
    acc = exp_rdy && req;
    @(posedge clk);
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (!rst) begin
      cyc++;
      if (clear_left > 0) begin
        clear_left--;
      end else if (clr) begin
        clear_left = DEPTH;
        for (int i = 0; i < 2**ADDR_W; i++) model_mem[i] = '0;
      end else if (acc) begin
        e.due = cyc + LAT - 1;
        if (int'(addr) >= DEPTH) begin
          e.valid = !we;
          e.err   = 1'b1;
          e.data  = '0;
          exp_q.push_back(e);
        end else if (we) begin
          for (int b = 0; b < BE_W; b++)
            if (be[b]) model_mem[addr][8*b +: 8] = din[8*b +: 8];
        end else begin
          e.valid = 1'b1;
          e.err   = 1'b0;
          e.data  = model_mem[addr];
          exp_q.push_back(e);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e       = exp_q.pop_front();
        e_valid = e.valid;
        e_err   = e.err;
        if (e.valid) last_dout = e.data;
      end
    end
    #1;
    chk("busy", DATA_W'(busy), DATA_W'(rst || clear_left > 0));
    chk("dout_valid", DATA_W'(dout_valid), DATA_W'(e_valid));
    chk("err", DATA_W'(err), DATA_W'(e_err));
    chk("dout", dout, last_dout);
  endtask

  // driver tasks
  task automatic access(input bit w, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] b, input logic [DATA_W-1:0] d);
    req = 1'b1; we = w; addr = a; be = b; din = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_busy", DATA_W'(busy), 1);
    chk("rst_ready", DATA_W'(ready), 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", DATA_W'(dout_valid), 0);
    chk("rst_err", DATA_W'(err), 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    req = 1'b0;
    clr = 1'b0;
    do begin
      tick();
      n++;
    end while (busy === 1'b1 && n < 4*DEPTH);
    chk(tag, DATA_W'(n), DATA_W'(DEPTH));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    cyc      = 0;
    model_reset();

    // 1: reset, clear lasts DEPTH cycles, whole array reads zero
    apply_reset();
    wait_clear("t1_busy_cycles");
    for (int a = 0; a < DEPTH; a++) access(1'b0, ADDR_W'(a), '0, '0);
    idle(LAT);

    // 2: byte write then read, latency and single-cycle valid
    access(1'b1, 7'd5, 4'b0001, 32'h0000_00A5);
    access(1'b0, 7'd5, '0, '0);
    idle(LAT - 1);
    chk("t2_dout", dout, 32'h0000_00A5);
    chk("t2_valid", DATA_W'(dout_valid), 1);
    idle(1);
    chk("t2_valid_pulse", DATA_W'(dout_valid), 0);
    chk("t2_dout_hold", dout, 32'h0000_00A5);

    // 3: partial byte-enable merge
    access(1'b1, 7'd7, 4'hF, 32'h1122_3344);
    access(1'b1, 7'd7, 4'b0101, 32'hAABB_CCDD);
    access(1'b0, 7'd7, '0, '0);
    idle(LAT - 1);
    chk("t3_merge", dout, 32'h11BB_33DD);
    idle(1);

    // 4: out-of-range write and read
    access(1'b1, 7'd120, 4'hF, 32'hDEAD_BEEF);
    idle(LAT - 1);
    chk("t4_wr_err", DATA_W'(err), 1);
    chk("t4_wr_novalid", DATA_W'(dout_valid), 0);
    idle(1);
    access(1'b0, 7'd120, '0, '0);
    idle(LAT - 1);
    chk("t4_rd_dout", dout, 0);
    chk("t4_rd_valid", DATA_W'(dout_valid), 1);
    chk("t4_rd_err", DATA_W'(err), 1);
    access(1'b0, 7'd7, '0, '0);
    idle(LAT);
    chk("t4_mem_intact", dout, 32'h11BB_33DD);

    // 5: clr with a pending req; read in last idle cycle still completes
    for (int a = 0; a < 4; a++) access(1'b1, ADDR_W'(a), 4'hF, DATA_W'(a + 1));
    access(1'b0, 7'd3, '0, '0);
    clr = 1'b1; req = 1'b1; we = 1'b1; addr = 7'd1; be = 4'hF; din = 32'h5555_5555;
    tick();
    chk("t5_rd_before_clr", dout, 32'd4);
    wait_clear("t5_busy_cycles");
    for (int a = 0; a < 4; a++) access(1'b0, ADDR_W'(a), '0, '0);
    idle(LAT);
    chk("t5_cleared", dout, 0);

    // 6: reset partway through the clear restarts it
    apply_reset();
    idle(50);
    apply_reset();
    wait_clear("t6_busy_cycles");

    // random traffic, including accesses while busy and occasional clr
    for (int i = 0; i < 600; i++) begin
      clr  = ($urandom_range(0, 79) == 0);
      req  = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      addr = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
      be   = BE_W'($urandom);
      din  = $urandom;
      tick();
    end
    clr = 1'b0;
    req = 1'b0;
    idle(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
